beam_readout_ctrl: RTL and testbench

//  Reader for the beamformer output signal RAM: after a frame is beamformed, drives the
//  RAM read port (sumout_address/sumouten) and captures output_value after read latency.

---
 rtl/beam_readout_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_beam_readout_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beam_readout_ctrl.sv
// beam_readout_ctrl
//   Streams one beamformed frame out of the output signal RAM.
//   A start pulse latches base_addr/num_samples. The block then issues RAM reads
//   (sumout_address/sumouten), captures output_value RD_LAT cycles later into a
//   small skid FIFO, and presents the FIFO head on a valid/ready stream (m_*).
//   Reads are only issued when the FIFO is certain to have room for them, so
//   back-pressure never drops or repeats a sample.
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   start                 1-cycle frame start (ignored unless idle)
//   base_addr             first RAM address of the frame
//   num_samples           frame length, 0..2**ADDR_W
//   sumout_address        RAM read address
//   sumouten              RAM read enable, high only on issuing cycles
//   output_value          RAM read data, valid RD_LAT cycles after issue
//   m_data/m_valid/m_last stream output (FIFO head), m_last on the final sample
//   m_ready               stream sink ready
//   busy                  high whenever a frame is in progress
//   done                  1-cycle pulse once the frame has fully left the block
module beam_readout_ctrl #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_samples,
  output logic [ADDR_W-1:0] sumout_address,
  output logic              sumouten,
  input  logic [DATA_W-1:0] output_value,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned INF_W = $clog2(RD_LAT + 1);
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_num;
  logic [ADDR_W:0]   r_issued;
  logic [ADDR_W:0]   w_issued_nxt;

  // Issue tracking: one bit per RAM latency stage, plus the frame-end marker.
  logic [RD_LAT-1:0] r_dl;
  logic [RD_LAT-1:0] r_dl_last;

  logic [DATA_W-1:0] r_mem      [FIFO_DEPTH];
  logic              r_mem_last [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_push;
  logic              w_pop;
  logic              w_issue;
  logic              w_final;
  logic              w_drained;
  logic [INF_W-1:0]  w_inflight;
  logic [OCC_W-1:0]  w_occ;
  logic [OCC_W-1:0]  w_cap;

  function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + INF_W'(r_dl[i]);
    end
  end

  assign w_push = r_dl[RD_LAT-1];
  assign w_pop  = m_valid && m_ready;

  // Reserve a FIFO slot for every outstanding read. A slot freed by a pop in
  // this same cycle is usable now, which keeps the stream at one sample per
  // cycle with only RD_LAT+1 entries.
  assign w_occ   = OCC_W'(r_count) + OCC_W'(w_inflight);
  assign w_cap   = OCC_W'(FIFO_DEPTH) + OCC_W'(w_pop);
  assign w_issue = (r_state == S_ISSUE) && (w_occ < w_cap);

  assign w_issued_nxt = r_issued + (ADDR_W + 1)'(1);
  assign w_final      = w_issue && (w_issued_nxt == r_num);

  // Frame is finished once nothing is in flight and the FIFO empties this cycle.
  assign w_drained = (w_inflight == '0) &&
                     ((r_count == '0) || ((r_count == CNT_W'(1)) && w_pop));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      // An empty frame passes through DRAIN, which exits at once, so done
      // lands two cycles after start.
      S_IDLE:  if (start) w_state_nxt = (num_samples == '0) ? S_DRAIN : S_ISSUE;
      S_ISSUE: if (w_final) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_drained) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base   <= '0;
      r_num    <= '0;
      r_issued <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_base   <= base_addr;
      r_num    <= num_samples;
      r_issued <= '0;
    end else if (w_issue) begin
      r_issued <= w_issued_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dl      <= '0;
      r_dl_last <= '0;
    end else begin
      r_dl[0]      <= w_issue;
      r_dl_last[0] <= w_final;
      for (int i = 1; i < RD_LAT; i++) begin
        r_dl[i]      <= r_dl[i-1];
        r_dl_last[i] <= r_dl_last[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i]      <= '0;
        r_mem_last[i] <= 1'b0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr]      <= output_value;
        r_mem_last[r_wptr] <= r_dl_last[RD_LAT-1];
        r_wptr             <= f_ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= f_ptr_inc(r_rptr);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Address arithmetic wraps modulo 2**ADDR_W by truncation.
  assign sumout_address = r_base + r_issued[ADDR_W-1:0];
  assign sumouten       = w_issue;

  assign m_valid = (r_count != '0);
  assign m_data  = r_mem[r_rptr];
  assign m_last  = m_valid && r_mem_last[r_rptr];

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_FIN);

endmodule

// File: tb/tb_beam_readout_ctrl.sv
// Directed bench for beam_readout_ctrl with a registered-output RAM model.
module tb_beam_readout_ctrl;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] base_addr;
  logic [11:0] num_samples;
  logic [10:0] sumout_address;
  logic        sumouten;
  logic [11:0] output_value = '0;
  logic [11:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  beam_readout_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .base_addr      (base_addr),
    .num_samples    (num_samples),
    .sumout_address (sumout_address),
    .sumouten       (sumouten),
    .output_value   (output_value),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_last         (m_last),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [11:0] ram_val(input logic [10:0] a);
    return {1'b0, a} ^ 12'hA5C;
  endfunction

  always @(posedge clk) if (sumouten) output_value <= ram_val(sumout_address);

  // Stream monitor, sampled mid-cycle.
  logic [11:0] xd[$];
  bit          xl[$];
  int          xc[$];
  logic [10:0] ia[$];
  int          ic[$];
  int          dc[$];
  int          stab_err, credit_err, idle_iss_err, valid_cnt, iss_tot, xfer_tot;
  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic [11:0] prev_d = '0;
  logic        prev_l = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_r && !(m_valid && m_data === prev_d && m_last === prev_l))
        stab_err++;
      if (sumouten) begin
        ia.push_back(sumout_address);
        ic.push_back(cyc);
        iss_tot++;
      end
      if (m_valid) valid_cnt++;
      if (m_valid && m_ready) begin
        xd.push_back(m_data);
        xl.push_back(m_last);
        xc.push_back(cyc);
        xfer_tot++;
      end
      if (iss_tot - xfer_tot > DEPTH) credit_err++;
      if (sumouten && (!busy || done)) idle_iss_err++;
      if (done) dc.push_back(cyc);
      prev_v = m_valid;
      prev_r = m_ready;
      prev_d = m_data;
      prev_l = m_last;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    xd.delete(); xl.delete(); xc.delete();
    ia.delete(); ic.delete(); dc.delete();
    stab_err = 0; credit_err = 0; idle_iss_err = 0;
    valid_cnt = 0; iss_tot = 0; xfer_tot = 0;
  endtask

  task automatic launch(input logic [10:0] b, input logic [11:0] n, output int k);
    k           = cyc;
    base_addr   = b;
    num_samples = n;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit tog);
    int i;
    i = 0;
    while (dc.size() == 0 && i < budget) begin
      if (tog) m_ready = ~m_ready;
      tick();
      i++;
    end
    chk("done_timeout", (dc.size() > 0) ? 1 : 0, 1);
    m_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic chk_stream(input string tag, input int b, input int n);
    int derr;
    int lerr;
    derr = 0;
    lerr = 0;
    chk({tag, "_xfer_count"}, xd.size(), n);
    for (int i = 0; i < xd.size() && i < n; i++) begin
      if (xd[i] !== ram_val(11'(b + i))) derr++;
      if (xl[i] !== (i == n - 1)) lerr++;
    end
    chk({tag, "_data_err"}, derr, 0);
    chk({tag, "_last_err"}, lerr, 0);
    chk({tag, "_done_count"}, dc.size(), 1);
    chk({tag, "_idle_issue"}, idle_iss_err, 0);
  endtask

  task automatic chk_addr(input string tag, input int b, input int n);
    int aerr;
    aerr = 0;
    chk({tag, "_issue_count"}, ia.size(), n);
    for (int i = 0; i < ia.size() && i < n; i++) begin
      if (ia[i] !== 11'(b + i)) aerr++;
    end
    chk({tag, "_addr_err"}, aerr, 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_m_valid"}, int'(m_valid), 0);
    chk({tag, "_sumouten"}, int'(sumouten), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_m_last"}, int'(m_last), 0);
    chk({tag, "_m_data"}, int'(m_data), 0);
    chk({tag, "_addr"}, int'(sumout_address), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  k;
    int  i;
    bit  again;

    rst         = 1'b1;
    start       = 1'b0;
    base_addr   = '0;
    num_samples = '0;
    m_ready     = 1'b0;
    clr();
    tick();
    tick();
    chk_zero_outputs("reset");
    rst = 1'b0;
    tick();

    // 1: contiguous frame, sink always ready
    clr();
    m_ready = 1'b1;
    launch(11'd0, 12'd8, k);
    wait_done(40, 1'b0);
    chk_stream("t1", 0, 8);
    chk_addr("t1", 0, 8);
    chk("t1_first_issue", (ic.size() > 0) ? ic[0] - k : -1, 1);
    chk("t1_issue_span", (ic.size() == 8) ? ic[7] - ic[0] : -1, 7);
    chk("t1_first_xfer", (xc.size() > 0) ? xc[0] - k : -1, 3);
    chk("t1_last_xfer", (xc.size() == 8) ? xc[7] - k : -1, 10);
    chk("t1_done_cycle", (dc.size() > 0) ? dc[0] - k : -1, 11);

    // 2: sink toggles ready every cycle
    clr();
    m_ready = 1'b0;
    launch(11'd100, 12'd16, k);
    wait_done(200, 1'b1);
    chk_stream("t2", 100, 16);
    chk_addr("t2", 100, 16);
    chk("t2_stall_stable", stab_err, 0);
    chk("t2_credit", credit_err, 0);

    // 3: address wrap at top of RAM
    clr();
    m_ready = 1'b1;
    launch(11'd2040, 12'd16, k);
    wait_done(60, 1'b0);
    chk_stream("t3", 2040, 16);
    chk_addr("t3", 2040, 16);

    // 4: empty frame
    clr();
    launch(11'd5, 12'd0, k);
    wait_done(10, 1'b0);
    chk("t4_issues", ia.size(), 0);
    chk("t4_valid_cycles", valid_cnt, 0);
    chk("t4_done_count", dc.size(), 1);
    chk("t4_done_cycle", (dc.size() > 0) ? dc[0] - k : -1, 2);

    // 5: second start while busy is ignored
    clr();
    again = 1'b0;
    launch(11'd300, 12'd10, k);
    i = 0;
    while (dc.size() == 0 && i < 60) begin
      if (!again && xd.size() == 5) begin
        base_addr   = 11'd700;
        num_samples = 12'd3;
        start       = 1'b1;
        again       = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      i++;
    end
    start = 1'b0;
    for (int j = 0; j < 10; j++) tick();
    chk("t5_restart_pulsed", int'(again), 1);
    chk_stream("t5", 300, 10);
    chk("t5_idle_after", int'(busy), 0);

    // 6: reset mid-frame with sink stalled, then a clean short frame
    clr();
    m_ready = 1'b1;
    launch(11'd0, 12'd12, k);
    i = 0;
    while (xd.size() < 4 && i < 30) begin
      tick();
      i++;
    end
    m_ready = 1'b0;
    tick();
    tick();
    chk("t6_busy_before", int'(busy), 1);
    chk("t6_valid_before", int'(m_valid), 1);
    #3;
    rst = 1'b1;
    #1;
    chk_zero_outputs("t6_async");
    tick();
    rst = 1'b0;
    tick();
    clr();
    m_ready = 1'b1;
    launch(11'd0, 12'd3, k);
    wait_done(30, 1'b0);
    chk_stream("t6", 0, 3);
    chk_addr("t6", 0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
